hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
Decode-stage hazard detector that produces the hazard_detected input of the decode controller, plus PC, IF/ID, ID/EXE and EXE/MEM control.
- Detects RAW hazards against the EXE and MEM stages, with load-use-only detection when forwarding is enabled.
- Sequences the multi-cycle MULT execution through a small FSM.
- Handles taken-branch flush of IF/ID and keeps a saturating stall-cycle performance counter.

Parameters:
REG_ADDR_W, 5, register-file address width (matches REG_FILE_ADDR_LEN in defines.v)
MULT_LAT, 4, total cycles a MULT occupies EXE; legal range 2..15
CNT_W, 16, stall performance counter width

Ports:
clk  in  1  clock
rst  in  1  reset
src1  in  REG_ADDR_W  ID-stage first source register
src2  in  REG_ADDR_W  ID-stage second source register
two_src  in  1  ID instruction reads src2 (~Is_Imm | ST_or_BNE)
exe_dest  in  REG_ADDR_W  destination register of the instruction in EXE
exe_wb_en  in  1  EXE instruction writes the register file
exe_mem_r_en  in  1  EXE instruction is a load
exe_mult  in  1  instruction in EXE is a MULT
mem_dest  in  REG_ADDR_W  destination register of the instruction in MEM
mem_wb_en  in  1  MEM instruction writes the register file
forward_en  in  1  forwarding unit active
branch_taken  in  1  EXE resolved a taken branch/jump
stall_cnt_clr  in  1  synchronous clear of the stall counter
hazard_detected  out  1  insert bubble into ID/EXE (to controller)
pc_freeze  out  1  hold PC
ifid_freeze  out  1  hold IF/ID
ifid_flush  out  1  clear IF/ID to NOP
idex_freeze  out  1  hold ID/EXE
exmem_bubble  out  1  load NOP into EXE/MEM
mult_busy  out  1  FSM in BUSY
stall_count  out  CNT_W  saturating count of pc_freeze cycles

Behaviour:
Clock and reset (already decided): one clock clk; reset rst is asynchronous, active-low.
- Reset forces state=IDLE, cnt=0, stall_count=0.
- After reset, outputs follow the combinational equations below with mult_stall=0.
- Reset asserted mid-MULT aborts the sequence immediately; the FSM restarts in IDLE.

Match and RAW hazard:
- match(d,en) = en & (d != 0) & (d==src1 | (two_src & d==src2)). Register 0 never hazards.
- forward_en=0: raw = match(exe_dest,exe_wb_en) | match(mem_dest,mem_wb_en).
- forward_en=1: raw = match(exe_dest,exe_wb_en & exe_mem_r_en). This is the load-use case only.

MULT FSM, states IDLE and BUSY, 4-bit cnt:
- IDLE: exe_mult=1 gives mult_stall=1; next state BUSY with cnt=MULT_LAT-2.
- BUSY, cnt!=0: mult_stall=1; cnt decrements.
- BUSY, cnt==0: mult_stall=0, so the MULT leaves EXE this cycle; next state IDLE.
- exe_mult is ignored while in BUSY, so the same MULT never retriggers.
- Net effect: a MULT holds EXE for exactly MULT_LAT cycles, with MULT_LAT-1 stall cycles.
- Back-to-back MULTs: the second is seen in IDLE on the following cycle and starts a new sequence.
- mult_busy = (state==BUSY).

Outputs (combinational, bt = branch_taken & ~mult_stall):
- hazard_detected = (raw & ~mult_stall) | bt
- pc_freeze = ifid_freeze = (raw | mult_stall) & ~bt
- ifid_flush = bt
- idex_freeze = exmem_bubble = mult_stall
- Branch has priority over a RAW hazard: PC loads the target and the wrong-path ID instruction becomes a bubble.
- branch_taken during mult_stall cannot legally occur; it is ignored.

stall_count, registered:
- stall_cnt_clr=1 gives 0 next cycle; clear wins over increment.
- Otherwise increments when pc_freeze=1.
- Saturates at all-ones with no wrap.

Decomposition:
- defines.v gains FSM state encodings HZ_IDLE/HZ_BUSY and default MULT_LAT.
- One sub-module, mult_stall_fsm: owns state and cnt; outputs mult_stall and mult_busy.
- The top level keeps the RAW comparators, output muxing and stall_count.

Test Plan:
- forward_en=0, src1=3, exe_dest=3, exe_wb_en=1 -> hazard_detected=1, pc_freeze=1; same with exe_dest=0 -> all 0.
- forward_en=1, src2=7, two_src=1, exe_dest=7, exe_wb_en=1, exe_mem_r_en=0 -> no hazard; set exe_mem_r_en=1 -> hazard; set two_src=0 -> no hazard.
- MULT_LAT=4, exe_mult=1 held at cycle t -> idex_freeze=1 at t..t+2, 0 at t+3; mult_busy=1 at t+1..t+3; with exe_mult still 1 at t+4 -> new stall sequence starts.
- raw=1 and branch_taken=1 in the same cycle -> ifid_flush=1, hazard_detected=1, pc_freeze=0.
- rst pulsed low at t+1 of a MULT -> mult_busy=0 and idex_freeze follows exe_mult immediately; stall_count=0.
- CNT_W=4 with pc_freeze held 20 cycles -> stall_count=15; stall_cnt_clr pulsed while freezing -> 0 next cycle.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared types and defaults for the decode-stage hazard unit.
package hazard_unit_pkg;

  typedef enum logic {
    HZ_IDLE = 1'b0,
    HZ_BUSY = 1'b1
  } hz_state_e;

  localparam int DEFAULT_REG_ADDR_W = 5;
  localparam int DEFAULT_MULT_LAT   = 4;
  localparam int DEFAULT_CNT_W      = 16;
  localparam int MULT_CNT_W         = 4;

endpackage

// File: rtl/mult_stall_fsm.sv
// Holds a MULT in EXE for MULT_LAT cycles by raising mult_stall for MULT_LAT-1 of them.
module mult_stall_fsm
  import hazard_unit_pkg::*;
#(
  parameter int MULT_LAT = DEFAULT_MULT_LAT
) (
  input  logic clk,
  input  logic rst,
  input  logic exe_mult,
  output logic mult_stall,
  output logic mult_busy
);

  localparam logic [MULT_CNT_W-1:0] CNT_LOAD = MULT_CNT_W'(MULT_LAT - 2);

  hz_state_e             state, state_next;
  logic [MULT_CNT_W-1:0] cnt, cnt_next;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= HZ_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    mult_stall = 1'b0;
    unique case (state)
      HZ_IDLE: begin
        if (exe_mult) begin
          mult_stall = 1'b1;
          state_next = HZ_BUSY;
          cnt_next   = CNT_LOAD;
        end
      end
      HZ_BUSY: begin
        // exe_mult is deliberately ignored here so the resident MULT never retriggers.
        if (cnt != '0) begin
          mult_stall = 1'b1;
          cnt_next   = cnt - 1'b1;
        end else begin
          state_next = HZ_IDLE;
        end
      end
      default: state_next = HZ_IDLE;
    endcase
  end

  assign mult_busy = (state == HZ_BUSY);

endmodule

// File: rtl/hazard_unit.sv
// Decode-stage hazard detector: RAW checks, MULT stall sequencing, branch flush, stall counter.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W,
  parameter int MULT_LAT   = DEFAULT_MULT_LAT,
  parameter int CNT_W      = DEFAULT_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] src1,
  input  logic [REG_ADDR_W-1:0] src2,
  input  logic                  two_src,
  input  logic [REG_ADDR_W-1:0] exe_dest,
  input  logic                  exe_wb_en,
  input  logic                  exe_mem_r_en,
  input  logic                  exe_mult,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  mem_wb_en,
  input  logic                  forward_en,
  input  logic                  branch_taken,
  input  logic                  stall_cnt_clr,
  output logic                  hazard_detected,
  output logic                  pc_freeze,
  output logic                  ifid_freeze,
  output logic                  ifid_flush,
  output logic                  idex_freeze,
  output logic                  exmem_bubble,
  output logic                  mult_busy,
  output logic [CNT_W-1:0]      stall_count
);

  logic exe_hit, mem_hit, raw, mult_stall, bt;

  // Register 0 is hard-wired to zero, so it can never be a true dependency.
  assign exe_hit = (exe_dest != '0) && ((exe_dest == src1) || (two_src && (exe_dest == src2)));
  assign mem_hit = (mem_dest != '0) && ((mem_dest == src1) || (two_src && (mem_dest == src2)));

  // With forwarding only a load in EXE cannot be bypassed in time.
  assign raw = forward_en ? (exe_hit && exe_wb_en && exe_mem_r_en)
                          : ((exe_hit && exe_wb_en) || (mem_hit && mem_wb_en));

  mult_stall_fsm #(
    .MULT_LAT (MULT_LAT)
  ) u_mult_stall_fsm (
    .clk        (clk),
    .rst        (rst),
    .exe_mult   (exe_mult),
    .mult_stall (mult_stall),
    .mult_busy  (mult_busy)
  );

  assign bt              = branch_taken && !mult_stall;
  assign hazard_detected = (raw && !mult_stall) || bt;
  assign pc_freeze       = (raw || mult_stall) && !bt;
  assign ifid_freeze     = pc_freeze;
  assign ifid_flush      = bt;
  assign idex_freeze     = mult_stall;
  assign exmem_bubble    = mult_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (stall_cnt_clr) begin
      stall_count <= '0;
    end else if (pc_freeze && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: stimulus pushes expectations, a negedge monitor pops and compares.
module tb_hazard_unit;

  localparam int AW   = 5;
  localparam int LAT  = 4;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] src1 = '0, src2 = '0, exe_dest = '0, mem_dest = '0;
  logic          two_src = 0, exe_wb_en = 0, exe_mem_r_en = 0, exe_mult = 0;
  logic          mem_wb_en = 0, forward_en = 0, branch_taken = 0, stall_cnt_clr = 0;
  logic          hazard_detected, pc_freeze, ifid_freeze, ifid_flush;
  logic          idex_freeze, exmem_bubble, mult_busy;
  logic [CW-1:0] stall_count;

  hazard_unit #(
    .REG_ADDR_W (AW),
    .MULT_LAT   (LAT),
    .CNT_W      (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .src1            (src1),
    .src2            (src2),
    .two_src         (two_src),
    .exe_dest        (exe_dest),
    .exe_wb_en       (exe_wb_en),
    .exe_mem_r_en    (exe_mem_r_en),
    .exe_mult        (exe_mult),
    .mem_dest        (mem_dest),
    .mem_wb_en       (mem_wb_en),
    .forward_en      (forward_en),
    .branch_taken    (branch_taken),
    .stall_cnt_clr   (stall_cnt_clr),
    .hazard_detected (hazard_detected),
    .pc_freeze       (pc_freeze),
    .ifid_freeze     (ifid_freeze),
    .ifid_flush      (ifid_flush),
    .idex_freeze     (idex_freeze),
    .exmem_bubble    (exmem_bubble),
    .mult_busy       (mult_busy),
    .stall_count     (stall_count)
  );

  always #5 clk = ~clk;

  // Expected vector layout: {hz, pc_frz, ifid_frz, flush, idex_frz, exmem_bub, busy, count[3:0]}
  logic [10:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;
  int          exp_cnt = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [10:0] req, act;
      string       nm;
      req = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = {hazard_detected, pc_freeze, ifid_freeze, ifid_flush,
             idex_freeze, exmem_bubble, mult_busy, stall_count};
      checks++;
      if (act !== req) begin
        errors++;
        $display("FAIL %s: got %b required %b (hz pcf iff flush idf exb busy cnt)", nm, act, req);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // e = {hz, pc_freeze, ifid_flush, idex_freeze, mult_busy}
  task automatic expect_out(input string nm, input logic [4:0] e);
    logic [3:0] c;
    c = rst ? 4'(exp_cnt) : 4'd0;
    exp_q.push_back({e[4], e[3], e[3], e[2], e[1], e[1], e[0], c});
    name_q.push_back(nm);
    if (!rst || stall_cnt_clr) exp_cnt = 0;
    else if (e[3] && exp_cnt != CMAX) exp_cnt++;
  endtask

  task automatic clear_inputs();
    src1 = '0; src2 = '0; exe_dest = '0; mem_dest = '0;
    two_src = 0; exe_wb_en = 0; exe_mem_r_en = 0; exe_mult = 0;
    mem_wb_en = 0; forward_en = 0; branch_taken = 0; stall_cnt_clr = 0;
  endtask

  initial begin
    tick(); expect_out("reset", 5'b00000);

    tick(); rst = 1; src1 = 3; exe_dest = 3; exe_wb_en = 1;
    expect_out("raw_exe", 5'b11000);
    tick(); exe_dest = 0;
    expect_out("r0_no_hazard", 5'b00000);
    tick(); exe_wb_en = 0; mem_dest = 3; mem_wb_en = 1;
    expect_out("raw_mem", 5'b11000);
    tick(); forward_en = 1;
    expect_out("fwd_mem_ignored", 5'b00000);

    tick(); clear_inputs(); forward_en = 1; src1 = 3; src2 = 7; two_src = 1;
    exe_dest = 7; exe_wb_en = 1;
    expect_out("fwd_no_load", 5'b00000);
    tick(); exe_mem_r_en = 1;
    expect_out("fwd_load_use", 5'b11000);
    tick(); two_src = 0;
    expect_out("fwd_one_src", 5'b00000);
    tick(); two_src = 1; branch_taken = 1;
    expect_out("branch_over_raw", 5'b10100);

    tick(); clear_inputs(); exe_mult = 1;
    expect_out("mult_t0", 5'b01010);
    tick(); expect_out("mult_t1", 5'b01011);
    tick(); expect_out("mult_t2", 5'b01011);
    tick(); expect_out("mult_t3_leave", 5'b00001);
    tick(); expect_out("mult_b2b_t4", 5'b01010);
    tick(); rst = 0;
    expect_out("reset_mid_mult", 5'b01010);
    tick(); rst = 1; exe_mult = 0;
    expect_out("after_reset", 5'b00000);

    tick(); src1 = 3; exe_dest = 3; exe_wb_en = 1;
    expect_out("sat_0", 5'b11000);
    for (int i = 1; i < 20; i++) begin
      tick(); expect_out($sformatf("sat_%0d", i), 5'b11000);
    end
    tick(); stall_cnt_clr = 1;
    expect_out("clr_cycle", 5'b11000);
    tick(); stall_cnt_clr = 0;
    expect_out("after_clr", 5'b11000);
    tick(); expect_out("count_again", 5'b11000);
    tick(); clear_inputs();
    expect_out("idle_end", 5'b00000);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
